// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA sync generator: hsync/vsync/vidon, pixel coordinates and line/frame strobes.
// Optional look-ahead outputs (pf_vidon/pf_hc/pf_vc) are enabled with `define VGA_PREFETCH_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          vidon,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_PREFETCH_EN
  ,
  output logic          pf_vidon,
  output logic [CW-1:0] pf_hc,
  output logic [CW-1:0] pf_vc
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_ON  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_OFF = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_ON  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_OFF = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Explicit wrap at TOTAL-1 so non-power-of-two totals never rely on 2^CW rollover.
  function automatic logic [CW-1:0] h_step(input logic [CW-1:0] h);
    return (h == H_LAST) ? '0 : h + CW'(1);
  endfunction

  function automatic logic [CW-1:0] v_step(input logic [CW-1:0] h, input logic [CW-1:0] v);
    if (h != H_LAST) return v;
    return (v == V_LAST) ? '0 : v + CW'(1);
  endfunction

  function automatic logic active(input logic [CW-1:0] h, input logic [CW-1:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  logic [CW-1:0] hc_n, vc_n;

  always_comb begin
    hc_n = h_step(hc);
    vc_n = v_step(hc, vc);
  end

  // Decodes use the next counter value so every output lines up with the hc/vc it is registered with.
  always_ff @(posedge clk) begin
    if (clr) begin
      hc          <= H_LAST;
      vc          <= V_LAST;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      vidon       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hc          <= hc_n;
      vc          <= vc_n;
      hsync       <= (hc_n >= HS_ON && hc_n < HS_OFF) ? HS_POL : ~HS_POL;
      vsync       <= (vc_n >= VS_ON && vc_n < VS_OFF) ? VS_POL : ~VS_POL;
      vidon       <= active(hc_n, vc_n);
      line_start  <= (hc_n == '0);
      frame_start <= (hc_n == '0) && (vc_n == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_PREFETCH_EN
  // pf_* always equals the position the counters load on the next tick, so it steps from itself.
  logic [CW-1:0] pf_hc_n, pf_vc_n;

  always_comb begin
    pf_hc_n = h_step(pf_hc);
    pf_vc_n = v_step(pf_hc, pf_vc);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pf_hc    <= '0;
      pf_vc    <= '0;
      pf_vidon <= 1'b1;
    end else if (en) begin
      pf_hc    <= pf_hc_n;
      pf_vc    <= pf_vc_n;
      pf_vidon <= active(pf_hc_n, pf_vc_n);
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three modes checked every cycle against a linear-position model,
// plus directed literal checks on reset, sync windows, wraps, en gating and mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // ---------------- DUT A: default 640x480, active-low syncs
  logic clr_a, en_a, hs_a, vs_a, vid_a, ls_a, fs_a;
  logic [9:0] hc_a, vc_a;
`ifdef VGA_PREFETCH_EN
  logic pv_a; logic [9:0] ph_a, pvc_a;
`endif
  vga_timing_gen dut_a (
    .clk(clk), .clr(clr_a), .en(en_a), .hsync(hs_a), .vsync(vs_a), .vidon(vid_a),
    .hc(hc_a), .vc(vc_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_PREFETCH_EN
    , .pf_vidon(pv_a), .pf_hc(ph_a), .pf_vc(pvc_a)
`endif
  );

  // ---------------- DUT B: 800x600, active-high syncs
  logic clr_b, en_b, hs_b, vs_b, vid_b, ls_b, fs_b;
  logic [10:0] hc_b, vc_b;
`ifdef VGA_PREFETCH_EN
  logic pv_b; logic [10:0] ph_b, pvc_b;
`endif
  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
  ) dut_b (
    .clk(clk), .clr(clr_b), .en(en_b), .hsync(hs_b), .vsync(vs_b), .vidon(vid_b),
    .hc(hc_b), .vc(vc_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_PREFETCH_EN
    , .pf_vidon(pv_b), .pf_hc(ph_b), .pf_vc(pvc_b)
`endif
  );

  // ---------------- DUT C: tiny 13x8 mode, narrow counters, mixed polarity (full frames fit the budget)
  logic clr_c, en_c, hs_c, vs_c, vid_c, ls_c, fs_c;
  logic [3:0] hc_c, vc_c;
`ifdef VGA_PREFETCH_EN
  logic pv_c; logic [3:0] ph_c, pvc_c;
`endif
  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .CW(4)
  ) dut_c (
    .clk(clk), .clr(clr_c), .en(en_c), .hsync(hs_c), .vsync(vs_c), .vidon(vid_c),
    .hc(hc_c), .vc(vc_c), .line_start(ls_c), .frame_start(fs_c)
`ifdef VGA_PREFETCH_EN
    , .pf_vidon(pv_c), .pf_hc(ph_c), .pf_vc(pvc_c)
`endif
  );

  // ---------------- Model: linear pixel position since the first tick after reset (-1 = reset state)
  int pos_a = -1, pos_b = -1, pos_c = -1;
  bit tk_a = 0, tk_b = 0, tk_c = 0;

  always @(posedge clk) begin
    if (clr_a) begin pos_a = -1; tk_a = 0; end
    else if (en_a) begin pos_a = (pos_a + 1) % (800 * 525); tk_a = 1; end
    else tk_a = 0;
    if (clr_b) begin pos_b = -1; tk_b = 0; end
    else if (en_b) begin pos_b = (pos_b + 1) % (1056 * 628); tk_b = 1; end
    else tk_b = 0;
    if (clr_c) begin pos_c = -1; tk_c = 0; end
    else if (en_c) begin pos_c = (pos_c + 1) % (13 * 8); tk_c = 1; end
    else tk_c = 0;
  end

  task automatic cmp(input string tag, input int pos, input bit tk,
                     input int ha, input int hf, input int hs, input int hb,
                     input int va, input int vf, input int vs, input int vb,
                     input bit hp, input bit vp,
                     input int ahc, input int avc, input bit ahs, input bit avs,
                     input bit avid, input bit als, input bit afs);
    int ht, vt, eh, ev;
    bit ehs, evs, evid;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (pos < 0) begin
      eh = ht - 1; ev = vt - 1; ehs = !hp; evs = !vp; evid = 0;
    end else begin
      eh = pos % ht; ev = pos / ht;
      ehs  = (eh >= ha + hf && eh < ha + hf + hs) ? hp : !hp;
      evs  = (ev >= va + vf && ev < va + vf + vs) ? vp : !vp;
      evid = (eh < ha) && (ev < va);
    end
    check({tag, ".hc"}, ahc, eh);
    check({tag, ".vc"}, avc, ev);
    check({tag, ".hsync"}, int'(ahs), int'(ehs));
    check({tag, ".vsync"}, int'(avs), int'(evs));
    check({tag, ".vidon"}, int'(avid), int'(evid));
    check({tag, ".line_start"}, int'(als), int'(tk && eh == 0));
    check({tag, ".frame_start"}, int'(afs), int'(tk && pos == 0));
  endtask

  task automatic pcmp(input string tag, input int pos, input int ha, input int va,
                      input int ht, input int vt, input bit apv, input int aph, input int apvc);
    int p;
    p = (pos + 1) % (ht * vt);
    check({tag, ".pf_hc"}, aph, p % ht);
    check({tag, ".pf_vc"}, apvc, p / ht);
    check({tag, ".pf_vidon"}, int'(apv), int'((p % ht) < ha && (p / ht) < va));
  endtask

  always @(posedge clk) begin
    #1;
    cmp("a", pos_a, tk_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
        hc_a, vc_a, hs_a, vs_a, vid_a, ls_a, fs_a);
    cmp("b", pos_b, tk_b, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1,
        hc_b, vc_b, hs_b, vs_b, vid_b, ls_b, fs_b);
    cmp("c", pos_c, tk_c, 6, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b1,
        hc_c, vc_c, hs_c, vs_c, vid_c, ls_c, fs_c);
`ifdef VGA_PREFETCH_EN
    pcmp("a", pos_a, 640, 480, 800, 525, pv_a, ph_a, pvc_a);
    pcmp("b", pos_b, 800, 600, 1056, 628, pv_b, ph_b, pvc_b);
    pcmp("c", pos_c, 6, 4, 13, 8, pv_c, ph_c, pvc_c);
`endif
  end

  // ---------------- Directed stimulus with literal expectations
  initial begin
    int lo, first, vid, mx, t0, t1, fsn, vsn;
    clr_a = 1; en_a = 1; clr_b = 1; en_b = 1; clr_c = 1; en_c = 1;
    repeat (2) @(negedge clk);
    check("a.rst_hc", hc_a, 799);
    check("a.rst_vc", vc_a, 524);
    check("a.rst_vidon", vid_a, 0);
    check("a.rst_hsync", hs_a, 1);
    check("a.rst_fs", fs_a, 0);

    clr_a = 0;
    @(negedge clk);
    check("a.first_hc", hc_a, 0);
    check("a.first_vc", vc_a, 0);
    check("a.first_vidon", vid_a, 1);
    check("a.first_fs", fs_a, 1);
    check("a.first_ls", ls_a, 1);
    @(negedge clk);
    check("a.second_hc", hc_a, 1);
    check("a.second_ls", ls_a, 0);
    check("a.second_fs", fs_a, 0);

    // rest of line 0 through the 799->0 wrap
    lo = 0; first = -1; vid = 0;
    for (int i = 0; i < 900 && !(hc_a == 0 && vc_a == 1); i++) begin
      @(negedge clk);
      if (!hs_a) begin if (first < 0) first = hc_a; lo++; end
      if (vid_a) vid++;
    end
    check("a.hsync_width", lo, 96);
    check("a.hsync_first", first, 656);
    check("a.vidon_count", vid, 639);
    check("a.wrap_vc", vc_a, 1);
    check("a.wrap_ls", ls_a, 1);

    // en pattern 1,0,0,1 right after a line start
    en_a = 0;
    @(negedge clk);
    check("a.hold1_hc", hc_a, 0);
    check("a.hold1_ls", ls_a, 0);
    @(negedge clk);
    check("a.hold2_hc", hc_a, 0);
    check("a.hold2_vid", vid_a, 1);
    en_a = 1;
    @(negedge clk);
    check("a.resume_hc", hc_a, 1);
    check("a.resume_ls", ls_a, 0);

    // mid-line reset with en high, then hold in reset state with en low
    repeat (50) @(negedge clk);
    clr_a = 1;
    @(negedge clk);
    check("a.midclr_hc", hc_a, 799);
    check("a.midclr_vc", vc_a, 524);
    check("a.midclr_vidon", vid_a, 0);
    clr_a = 0; en_a = 0;
    repeat (3) @(negedge clk);
    check("a.idle_hc", hc_a, 799);
    check("a.idle_fs", fs_a, 0);
    en_a = 1;
    @(negedge clk);
    check("a.restart_fs", fs_a, 1);
    check("a.restart_hc", hc_a, 0);
    en_a = 0;

    // 800x600, active-high hsync window and 1055 wrap
    clr_b = 0;
    mx = 0; lo = 0; first = -1;
    for (int i = 0; i < 4000 && vc_b != 3; i++) begin
      @(negedge clk);
      if (vc_b == 0 && hs_b) begin if (first < 0) first = hc_b; lo++; end
      if (hc_b > mx) mx = hc_b;
    end
    check("b.hc_max", mx, 1055);
    check("b.hsync_width", lo, 128);
    check("b.hsync_first", first, 840);
    check("b.line3_hc", hc_b, 0);
    for (int i = 0; i < 1100 && hc_b != 300; i++) @(negedge clk);
    check("b.at_300", hc_b, 300);
    clr_b = 1;
    @(negedge clk);
    check("b.clr_hc", hc_b, 1055);
    check("b.clr_vc", vc_b, 627);
    check("b.clr_hsync", hs_b, 0);
    check("b.clr_vsync", vs_b, 0);
    check("b.clr_vidon", vid_b, 0);
    clr_b = 0; en_b = 0;

    // tiny mode: frame period, vsync and vidon per frame
    clr_c = 0;
    fsn = 0; vsn = 0; vid = 0; t0 = 0; t1 = -1;
    for (int i = 0; i < 400 && fsn < 2; i++) begin
      @(negedge clk);
      if (fs_c) begin
        if (fsn == 0) t0 = i; else t1 = i - t0;
        fsn++;
      end
      if (fsn == 1 && vs_c) vsn++;
      if (fsn == 1 && vid_c) vid++;
    end
    check("c.frame_period", t1, 104);
    check("c.vsync_clks", vsn, 26);
    check("c.vidon_clks", vid, 24);

    // random en gating with occasional reset; the per-cycle model covers it
    for (int i = 0; i < 400; i++) begin
      en_c  = 1'($urandom_range(0, 1));
      clr_c = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    clr_c = 0; en_c = 1;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
